// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, fetch defaults and the
// fetch-stage state encoding.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'd96;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // Word-align a fetch address by clearing the byte-offset bits.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: synchronous reset, then load > hold > increment.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [XLEN-1:0] PC_STEP  = cpu_pkg::PC_STEP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_value,
  input  logic            hold,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_reg_q;
  logic [XLEN-1:0] pc_next;

  always_comb begin
    pc_next = pc_reg_q + PC_STEP;  // wraps modulo 2^32
    if (load) begin
      pc_next = load_value;
    end else if (hold) begin
      pc_next = pc_reg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg_q <= RESET_PC;
    end else begin
      pc_reg_q <= pc_next;
    end
  end

  assign pc = pc_reg_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID pipeline register with
// stall/redirect handling and a small BOOT/RUN/HOLD fetch FSM.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [XLEN-1:0] PC_STEP   = cpu_pkg::PC_STEP,
  parameter logic [XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic [XLEN-1:0] ifid_instr,
  output logic            misalign
);

  logic [XLEN-1:0] pc;
  fetch_state_e    state_reg;
  fetch_state_e    state_next;

  logic            ifid_valid_reg;
  logic [XLEN-1:0] ifid_pc_reg;
  logic [XLEN-1:0] ifid_pc_plus4_reg;
  logic [XLEN-1:0] ifid_instr_reg;
  logic            misalign_reg;

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (redirect_valid),
    .load_value (align_word(redirect_target)),
    .hold       (stall),
    .pc         (pc)
  );

  // Redirect always lands in RUN; the flushed IF/ID is the single bubble.
  always_comb begin
    state_next = state_reg;
    if (redirect_valid) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        BOOT:    if (!stall) state_next = RUN;
        RUN:     if (stall)  state_next = HOLD;
        HOLD:    if (!stall) state_next = RUN;
        default: state_next = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid_reg    <= 1'b0;
      ifid_pc_reg       <= '0;
      ifid_pc_plus4_reg <= '0;
      ifid_instr_reg    <= NOP_INSTR;
      misalign_reg      <= 1'b0;
    end else if (redirect_valid) begin
      // Flush wins over stall; ifid_pc/ifid_pc_plus4 keep their old values.
      ifid_valid_reg <= 1'b0;
      ifid_instr_reg <= NOP_INSTR;
      misalign_reg   <= |redirect_target[1:0];
    end else begin
      misalign_reg <= 1'b0;
      if (!stall) begin
        ifid_valid_reg    <= 1'b1;
        ifid_pc_reg       <= pc;
        ifid_pc_plus4_reg <= pc + PC_STEP;
        ifid_instr_reg    <= imem_rdata;
      end
    end
  end

  assign imem_addr     = pc;
  assign ifid_valid    = ifid_valid_reg;
  assign ifid_pc       = ifid_pc_reg;
  assign ifid_pc_plus4 = ifid_pc_plus4_reg;
  assign ifid_instr    = ifid_instr_reg;
  assign misalign      = misalign_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: reset, advance, stall, redirect,
// misalignment, PC wrap-around and reset priority.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        misalign;

  int tests_run    = 0;
  int tests_failed = 0;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .ifid_valid      (ifid_valid),
    .ifid_pc         (ifid_pc),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_instr      (ifid_instr),
    .misalign        (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word tagged with the low half of its address.
  assign imem_rdata = {imem_addr[15:0], 16'hC0DE};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st();
    return 32'(dut.state_reg);
  endfunction

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;

    // Reset held for two cycles
    step();
    chk("rst_addr",    imem_addr, 32'd96);
    chk("rst_valid",   32'(ifid_valid), 32'd0);
    chk("rst_instr",   ifid_instr, 32'h0);
    chk("rst_pc",      ifid_pc, 32'h0);
    chk("rst_plus4",   ifid_pc_plus4, 32'h0);
    chk("rst_mis",     32'(misalign), 32'd0);
    step();
    chk("rst2_addr",   imem_addr, 32'd96);
    chk("boot_state",  st(), 32'd0);
    rst = 1'b0;

    // Advance
    step();
    chk("adv1_pc",     ifid_pc, 32'd96);
    chk("adv1_valid",  32'(ifid_valid), 32'd1);
    chk("adv1_addr",   imem_addr, 32'd100);
    chk("adv1_instr",  ifid_instr, 32'h0060_C0DE);
    chk("adv1_state",  st(), 32'd1);
    step();
    chk("adv2_pc",     ifid_pc, 32'd100);
    chk("adv2_plus4",  ifid_pc_plus4, 32'd104);
    step();
    chk("adv3_pc",     ifid_pc, 32'd104);
    chk("adv3_addr",   imem_addr, 32'd108);

    // Stall three cycles at pc=108
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr",  imem_addr, 32'd108);
      chk("stall_pc",    ifid_pc, 32'd104);
      chk("stall_instr", ifid_instr, 32'h0068_C0DE);
      chk("stall_valid", 32'(ifid_valid), 32'd1);
      chk("stall_state", st(), 32'd2);
    end
    stall = 1'b0;
    step();
    chk("unstall_pc",    ifid_pc, 32'd108);
    chk("unstall_plus4", ifid_pc_plus4, 32'd112);
    chk("unstall_addr",  imem_addr, 32'd112);

    // Redirect while stalled
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
    step();
    chk("redir_addr",  imem_addr, 32'h200);
    chk("redir_valid", 32'(ifid_valid), 32'd0);
    chk("redir_instr", ifid_instr, 32'h0);
    chk("redir_pc",    ifid_pc, 32'd108);
    chk("redir_mis",   32'(misalign), 32'd0);
    chk("redir_state", st(), 32'd1);
    stall = 1'b0; redirect_valid = 1'b0;
    step();
    chk("tgt_pc",      ifid_pc, 32'h200);
    chk("tgt_valid",   32'(ifid_valid), 32'd1);
    chk("tgt_instr",   ifid_instr, 32'h0200_C0DE);
    chk("tgt_plus4",   ifid_pc_plus4, 32'h204);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_target = 32'h203;
    step();
    chk("mis_addr",    imem_addr, 32'h200);
    chk("mis_flag",    32'(misalign), 32'd1);
    redirect_valid = 1'b0;
    step();
    chk("mis_clear",   32'(misalign), 32'd0);
    chk("mis_pc",      ifid_pc, 32'h200);

    // Wrap-around
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_addr",   imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step();
    chk("wrap_pc",     ifid_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4",  ifid_pc_plus4, 32'h0);
    chk("wrap_addr2",  imem_addr, 32'h0);
    step();
    chk("wrap2_pc",    ifid_pc, 32'h0);
    chk("wrap2_plus4", ifid_pc_plus4, 32'h4);

    // Reset coincident with redirect and stall at pc=0x300
    redirect_valid = 1'b1; redirect_target = 32'h300;
    step();
    chk("pre_addr",    imem_addr, 32'h300);
    rst = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h401;
    step();
    chk("rprio_addr",  imem_addr, 32'd96);
    chk("rprio_valid", 32'(ifid_valid), 32'd0);
    chk("rprio_mis",   32'(misalign), 32'd0);
    chk("rprio_state", st(), 32'd0);
    rst = 1'b0; redirect_valid = 1'b0;

    // Stall in BOOT holds BOOT
    step();
    chk("bstall_state", st(), 32'd0);
    chk("bstall_addr",  imem_addr, 32'd96);
    chk("bstall_valid", 32'(ifid_valid), 32'd0);
    stall = 1'b0;
    step();
    chk("boot_adv_pc",    ifid_pc, 32'd96);
    chk("boot_adv_valid", 32'(ifid_valid), 32'd1);
    chk("boot_adv_state", st(), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'd96: PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 32'd4: sequential PC increment.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0000: instruction word inserted on bubble/flush.
REQ-004 clk  input  1: single clock; all state updates on posedge clk.
REQ-005 rst  input  1: reset, synchronous, active-high.
REQ-006 stall  input  1: downstream hold request; freezes PC and IF/ID register.
REQ-007 redirect_valid  input  1: branch/jump taken, one-cycle pulse from downstream.
REQ-008 redirect_target  input  32: new fetch address, sampled when redirect_valid=1.
REQ-009 imem_addr  output  32: instruction memory address, equal to current PC (combinational from PC register).
REQ-010 imem_rdata  input  32: instruction word, asynchronous read of imem_addr in the same cycle.
REQ-011 ifid_valid  output  1: IF/ID register holds a real instruction.
REQ-012 ifid_pc  output  32: PC of the instruction in IF/ID.
REQ-013 ifid_pc_plus4  output  32: ifid_pc + PC_STEP, registered.
REQ-014 ifid_instr  output  32: instruction word in IF/ID.
REQ-015 misalign  output  1: one-cycle pulse, registered, when an accepted redirect_target had bits [1:0] != 0.

Function
REQ-016 Per-edge priority: rst > redirect_valid > stall > normal advance.
REQ-017 Normal advance: ifid_pc<=pc, ifid_pc_plus4<=pc+PC_STEP, ifid_instr<=imem_rdata, ifid_valid<=1, pc<=pc+PC_STEP; latency PC-to-IF/ID is one cycle.
REQ-018 Stall (no redirect): pc, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr all hold; imem_addr constant.
REQ-019 Redirect: pc<={redirect_target[31:2],2'b00}; IF/ID flushed (ifid_valid<=0, ifid_instr<=NOP_INSTR, ifid_pc/ifid_pc_plus4 hold); applies even when stall=1.
REQ-020 Redirect flush produces exactly one bubble; the next non-stalled edge captures the target instruction with ifid_valid=1.
REQ-021 misalign<=|redirect_target[1:0] on an accepted redirect, else 0; the aligned address is used regardless.
REQ-022 PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000, ifid_pc_plus4 likewise wraps; no flag.
REQ-023 FSM states: BOOT (first cycle after reset, emits bubble), RUN (advancing), HOLD (stall=1 in RUN); BOOT->RUN on the first non-reset edge with stall=0 (stall in BOOT holds BOOT); RUN->HOLD on stall; HOLD->RUN on stall=0; any state->RUN on redirect (via flush); any state->BOOT on rst.
REQ-024 In BOOT, ifid_valid stays 0 while pc holds RESET_PC until the first advance edge.

Reset
REQ-025 On a rst edge: pc<=RESET_PC, ifid_valid<=0, ifid_pc<=0, ifid_pc_plus4<=0, ifid_instr<=NOP_INSTR, misalign<=0, state<=BOOT.
REQ-026 Reset asserted mid-operation (including during stall or coincident redirect) overrides all other inputs on that edge.
REQ-027 No initial-block state is relied upon; reset alone defines all register values.

Structure
REQ-028 Shared package cpu_pkg holds XLEN=32, RESET_PC, PC_STEP, NOP_INSTR and the fetch-state enum (BOOT, RUN, HOLD).
REQ-029 One sub-module pc_reg (PC register with load/hold/increment controls and synchronous reset) is instantiated; IF/ID register and FSM live in if_stage.

Verification
REQ-030 Reset 2 cycles then release, stall=0 -> imem_addr=96 during reset; after first advance edge ifid_pc=96, ifid_valid=1, imem_addr=100; next edge ifid_pc=100, ifid_pc_plus4=104.
REQ-031 stall=1 for 3 cycles at pc=108 -> imem_addr=108 and IF/ID unchanged for all 3 cycles; release -> ifid_pc=108 next edge.
REQ-032 redirect_valid=1, target=32'h200 while stall=1 -> next cycle imem_addr=0x200, ifid_valid=0, ifid_instr=NOP; following edge ifid_pc=0x200, ifid_valid=1.
REQ-033 redirect target=32'h203 -> imem_addr=0x200, misalign=1 for exactly one cycle.
REQ-034 redirect target=32'hFFFF_FFFC, then advance twice -> ifid_pc=0xFFFF_FFFC with ifid_pc_plus4=0, then ifid_pc=0.
REQ-035 rst asserted together with redirect_valid and stall at pc=0x300 -> next cycle imem_addr=96, ifid_valid=0, misalign=0, state BOOT.
